// File: rtl/fpu_div_pkg.sv
// Shared encodings and constants for the divide exponent sequencing logic.
package fpu_div_pkg;

  localparam int ITER_DBL_DEF = 55;
  localparam int ITER_SNG_DEF = 26;
  localparam int CNT_W_DEF    = 6;

  localparam logic [12:0] EXP1_0835 = 13'h0835;
  localparam logic [12:0] EXP1_0118 = 13'h0118;

  typedef enum logic [1:0] {
    SR_NORM = 2'b00,
    SR_ZERO = 2'b01,
    SR_0835 = 2'b10,
    SR_0118 = 2'b11
  } special_res_e;

  // exp1_sel one-hot order is {expadd1, 0835, 0118, zero}
  localparam logic [3:0] EXP1_SEL_ADD  = 4'b1000;
  localparam logic [3:0] EXP1_SEL_0835 = 4'b0100;
  localparam logic [3:0] EXP1_SEL_0118 = 4'b0010;
  localparam logic [3:0] EXP1_SEL_ZERO = 4'b0001;

  typedef enum logic [10:0] {
    S_IDLE = 11'b000_0000_0001,
    S_D1   = 11'b000_0000_0010,
    S_D2   = 11'b000_0000_0100,
    S_D3   = 11'b000_0000_1000,
    S_D4   = 11'b000_0001_0000,
    S_D5   = 11'b000_0010_0000,
    S_ITER = 11'b000_0100_0000,
    S_B5   = 11'b000_1000_0000,
    S_B6   = 11'b001_0000_0000,
    S_B7   = 11'b010_0000_0000,
    S_DONE = 11'b100_0000_0000
  } state_e;

  function automatic logic [3:0] exp1_sel_of(input logic [1:0] sr);
    logic [3:0] sel;
    case (special_res_e'(sr))
      SR_ZERO: sel = EXP1_SEL_ZERO;
      SR_0835: sel = EXP1_SEL_0835;
      SR_0118: sel = EXP1_SEL_0118;
      default: sel = EXP1_SEL_ADD;
    endcase
    return sel;
  endfunction

  // Constant the exp1 mux presents for a given one-hot select.
  function automatic logic [12:0] exp1_const_of(input logic [3:0] sel);
    logic [12:0] val;
    case (sel)
      EXP1_SEL_0835: val = EXP1_0835;
      EXP1_SEL_0118: val = EXP1_0118;
      default:       val = 13'h0000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/fpu_div_exp_ctl_if.sv
// Request handshake plus all exponent-datapath controls of the divide sequencer.
interface fpu_div_exp_ctl_if;
  logic       req_vld;
  logic       req_dbl;
  logic       req_rdy;
  logic [1:0] special_res;
  logic       no_decr;
  logic       rnd_cin;
  logic       hold;
  logic       d1stg_step;
  logic       sel_exp1_fb;
  logic       sel_in1_dbl;
  logic       sel_in1_sng;
  logic       sel_in2_dbl;
  logic       sel_in2_sng;
  logic       sel_sub_shl;
  logic       sel_add_shl;
  logic [3:0] exp1_sel;
  logic       exp1_load;
  logic       e5_fdiva;
  logic       e5_fdivd;
  logic       e5_fdivs;
  logic       e6_fdiv;
  logic       e7_fdiv;
  logic       expadd2_cin;
  logic       exp_out_load;
  logic       div_done;

  modport master (
    output req_vld, req_dbl, special_res, no_decr, rnd_cin, hold,
    input  req_rdy, d1stg_step, sel_exp1_fb, sel_in1_dbl, sel_in1_sng,
           sel_in2_dbl, sel_in2_sng, sel_sub_shl, sel_add_shl, exp1_sel,
           exp1_load, e5_fdiva, e5_fdivd, e5_fdivs, e6_fdiv, e7_fdiv,
           expadd2_cin, exp_out_load, div_done
  );

  modport slave (
    input  req_vld, req_dbl, special_res, no_decr, rnd_cin, hold,
    output req_rdy, d1stg_step, sel_exp1_fb, sel_in1_dbl, sel_in1_sng,
           sel_in2_dbl, sel_in2_sng, sel_sub_shl, sel_add_shl, exp1_sel,
           exp1_load, e5_fdiva, e5_fdivd, e5_fdivs, e6_fdiv, e7_fdiv,
           expadd2_cin, exp_out_load, div_done
  );
endinterface

// File: rtl/fpu_div_iter_cnt.sv
// Loadable mantissa-iteration down-counter; frozen by hold, saturates at zero.
module fpu_div_iter_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fpu_div_exp_ctl.sv
// Divide exponent sequencer: front-end D1-D5, mantissa ITER, back-end B5-B7, DONE.
// FPU_DIV_EARLY_OUT_EN: a special result seen in D3 skips ITER (9-cycle latency).
module fpu_div_exp_ctl
  import fpu_div_pkg::*;
#(
  parameter int ITER_DBL = ITER_DBL_DEF,
  parameter int ITER_SNG = ITER_SNG_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic              rclk,
  input logic              reset,
  fpu_div_exp_ctl_if.slave bus
);

  state_e           state_q, state_d;
  logic             dbl_q, dbl_d;
  logic             accept;
  logic             skip_iter;
  logic             cnt_zero;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_ld_val;

  assign accept = (state_q == S_IDLE) && bus.req_vld && !bus.hold;
  assign dbl_d  = accept ? bus.req_dbl : dbl_q;

`ifdef FPU_DIV_EARLY_OUT_EN
  logic skip_q, skip_d;

  always_comb begin
    skip_d = skip_q;
    if (accept) begin
      skip_d = 1'b0;
    end else if ((state_q == S_D3) && !bus.hold && (bus.special_res != SR_NORM)) begin
      skip_d = 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) skip_q <= 1'b0;
    else       skip_q <= skip_d;
  end

  assign skip_iter = skip_q;
`else
  assign skip_iter = 1'b0;
`endif

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dbl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dbl_q   <= dbl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_vld) state_d = S_D1;
      S_D1:    state_d = S_D2;
      S_D2:    state_d = S_D3;
      S_D3:    state_d = S_D4;
      S_D4:    state_d = S_D5;
      S_D5:    state_d = skip_iter ? S_B5 : S_ITER;
      S_ITER:  if (cnt_zero) state_d = S_B5;
      S_B5:    state_d = S_B6;
      S_B6:    state_d = S_B7;
      S_B7:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.hold) state_d = state_q;
  end

  // Counter is loaded with N-1 on ITER entry so ITER spans exactly N cycles.
  assign cnt_load   = (state_q == S_D5) && (state_d == S_ITER);
  assign cnt_ld_val = dbl_q ? CNT_W'(ITER_DBL - 1) : CNT_W'(ITER_SNG - 1);

  fpu_div_iter_cnt #(
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .rclk       (rclk),
    .reset      (reset),
    .hold_i     (bus.hold),
    .load_i     (cnt_load),
    .load_val_i (cnt_ld_val),
    .dec_i      (state_q == S_ITER),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    bus.req_rdy      = 1'b0;
    bus.d1stg_step   = 1'b0;
    bus.sel_exp1_fb  = 1'b0;
    bus.sel_in1_dbl  = 1'b0;
    bus.sel_in1_sng  = 1'b0;
    bus.sel_in2_dbl  = 1'b0;
    bus.sel_in2_sng  = 1'b0;
    bus.sel_sub_shl  = 1'b0;
    bus.sel_add_shl  = 1'b0;
    bus.exp1_sel     = 4'b0000;
    bus.exp1_load    = 1'b0;
    bus.e5_fdiva     = 1'b0;
    bus.e5_fdivd     = 1'b0;
    bus.e5_fdivs     = 1'b0;
    bus.e6_fdiv      = 1'b0;
    bus.e7_fdiv      = 1'b0;
    bus.expadd2_cin  = 1'b0;
    bus.exp_out_load = 1'b0;
    bus.div_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_rdy    = !bus.hold;
        bus.d1stg_step = accept;
      end
      S_D2: begin
        bus.exp1_sel    = EXP1_SEL_ADD;
        bus.exp1_load   = !bus.hold;
        bus.sel_in1_dbl = dbl_q;
        bus.sel_in1_sng = !dbl_q;
      end
      S_D3: begin
        bus.exp1_sel    = exp1_sel_of(bus.special_res);
        bus.exp1_load   = !bus.hold;
        bus.sel_exp1_fb = 1'b1;
        bus.sel_in2_dbl = dbl_q;
        bus.sel_in2_sng = !dbl_q;
      end
      S_D4: begin
        bus.exp1_sel    = EXP1_SEL_ADD;
        bus.exp1_load   = !bus.hold;
        bus.sel_exp1_fb = 1'b1;
        bus.sel_sub_shl = 1'b1;
      end
      S_D5: begin
        bus.exp1_sel    = EXP1_SEL_ADD;
        bus.exp1_load   = !bus.hold;
        bus.sel_exp1_fb = 1'b1;
        bus.sel_add_shl = 1'b1;
      end
      S_B5: begin
        bus.e5_fdiva     = 1'b1;
        bus.e5_fdivd     = dbl_q;
        bus.e5_fdivs     = !dbl_q;
        bus.exp_out_load = !bus.hold;
      end
      S_B6: begin
        // Adder-2 carry doubles as the no-decrement input in this stage.
        bus.e6_fdiv      = 1'b1;
        bus.expadd2_cin  = !bus.no_decr;
        bus.exp_out_load = !bus.hold;
      end
      S_B7: begin
        bus.e7_fdiv      = 1'b1;
        bus.expadd2_cin  = bus.rnd_cin;
        bus.exp_out_load = !bus.hold;
      end
      S_DONE: begin
        bus.div_done = !bus.hold;
      end
      default: begin
      end
    endcase
  end

  a_in1_excl: assert property (@(posedge rclk) disable iff (reset)
    $onehot0({bus.sel_exp1_fb, bus.sel_in1_dbl, bus.sel_in1_sng}));
  a_in2_excl: assert property (@(posedge rclk) disable iff (reset)
    $onehot0({bus.sel_in2_dbl, bus.sel_in2_sng, bus.sel_sub_shl, bus.sel_add_shl}));
  a_exp1_excl: assert property (@(posedge rclk) disable iff (reset)
    $onehot0(bus.exp1_sel));
  a_be_excl: assert property (@(posedge rclk) disable iff (reset)
    $onehot0({bus.e5_fdiva, bus.e6_fdiv, bus.e7_fdiv}) && $onehot0({bus.e5_fdivd, bus.e5_fdivs}));

endmodule

// File: tb/tb_fpu_div_exp_ctl.sv
// Directed bench for the divide exponent sequencer: timing, selects, hold and reset.
module tb_fpu_div_exp_ctl;

  logic rclk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  fpu_div_exp_ctl_if bus ();

  fpu_div_exp_ctl #(
    .ITER_DBL (55),
    .ITER_SNG (26),
    .CNT_W    (6)
  ) dut (
    .rclk  (rclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 rclk = ~rclk;

`ifdef FPU_DIV_EARLY_OUT_EN
  localparam int LAT_SR_D = 9;
  localparam int LAT_SR_S = 9;
`else
  localparam int LAT_SR_D = 64;
  localparam int LAT_SR_S = 35;
`endif

  typedef struct packed {
    logic       d1;
    logic       rdy;
    logic       fb;
    logic       in1d;
    logic       in1s;
    logic       in2d;
    logic       in2s;
    logic       sub;
    logic       add;
    logic [3:0] sel;
    logic       ld1;
    logic       e5a;
    logic       e5d;
    logic       e5s;
    logic       e6;
    logic       e7;
    logic       cin;
    logic       ldo;
    logic       done;
  } snap_t;

  snap_t obs [0:199];

  function automatic snap_t take();
    snap_t s;
    s.d1   = bus.d1stg_step;
    s.rdy  = bus.req_rdy;
    s.fb   = bus.sel_exp1_fb;
    s.in1d = bus.sel_in1_dbl;
    s.in1s = bus.sel_in1_sng;
    s.in2d = bus.sel_in2_dbl;
    s.in2s = bus.sel_in2_sng;
    s.sub  = bus.sel_sub_shl;
    s.add  = bus.sel_add_shl;
    s.sel  = bus.exp1_sel;
    s.ld1  = bus.exp1_load;
    s.e5a  = bus.e5_fdiva;
    s.e5d  = bus.e5_fdivd;
    s.e5s  = bus.e5_fdivs;
    s.e6   = bus.e6_fdiv;
    s.e7   = bus.e7_fdiv;
    s.cin  = bus.expadd2_cin;
    s.ldo  = bus.exp_out_load;
    s.done = bus.div_done;
    return s;
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Issues one request from IDLE and logs outputs per cycle; cycle 0 is the accept cycle.
  task automatic run_req(input logic dbl, input logic [1:0] sr, input int hold_at,
                         input int hold_len, output int lat, output int ndone);
    lat   = -1;
    ndone = 0;
    bus.req_vld     = 1'b1;
    bus.req_dbl     = dbl;
    bus.special_res = sr;
    bus.hold        = 1'b0;
    #1;
    obs[0] = take();
    for (int n = 1; n < 200; n++) begin
      tick();
      bus.req_vld = 1'b0;
      bus.hold    = (n >= hold_at) && (n < hold_at + hold_len);
      #1;
      obs[n] = take();
      if (obs[n].done) begin
        ndone++;
        if (lat < 0) lat = n;
      end
      if (lat >= 0 && n >= lat + 3) break;
    end
    bus.hold = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.req_rdy !== 1'b1) $display("FAIL rst_rdy_in_reset got %b want 1", bus.req_rdy); else passed++;
    reset = 1'b0;
    tick();
    checks++; if (bus.req_rdy !== 1'b1) $display("FAIL rst_rdy got %b want 1", bus.req_rdy); else passed++;
    checks++;
    if ({bus.div_done, bus.exp1_load, bus.exp_out_load, bus.d1stg_step, bus.e5_fdiva, bus.expadd2_cin} !== 6'b0)
      $display("FAIL rst_ctl got %b want 000000",
               {bus.div_done, bus.exp1_load, bus.exp_out_load, bus.d1stg_step, bus.e5_fdiva, bus.expadd2_cin});
    else passed++;
    checks++; if (bus.exp1_sel !== 4'b0000) $display("FAIL rst_exp1_sel got %b want 0000", bus.exp1_sel); else passed++;
  endtask

  task automatic test_double();
    int lat, nd;
    bus.no_decr = 1'b1;
    bus.rnd_cin = 1'b0;
    run_req(1'b1, 2'b00, 0, 0, lat, nd);
    checks++; if (lat !== 64) $display("FAIL dbl_latency got %0d want 64", lat); else passed++;
    checks++; if (nd !== 1) $display("FAIL dbl_done_count got %0d want 1", nd); else passed++;
    checks++; if ({obs[0].rdy, obs[0].d1, obs[1].d1} !== 3'b110) $display("FAIL dbl_accept got %b want 110", {obs[0].rdy, obs[0].d1, obs[1].d1}); else passed++;
    for (int n = 1; n <= 6; n++) begin
      checks++;
      if (obs[n].ld1 !== (n >= 2 && n <= 5)) $display("FAIL dbl_exp1_load cyc %0d got %b want %b", n, obs[n].ld1, (n >= 2 && n <= 5));
      else passed++;
    end
    checks++; if ({obs[2].in1d, obs[2].in1s, obs[2].fb} !== 3'b100) $display("FAIL dbl_d2_in1 got %b want 100", {obs[2].in1d, obs[2].in1s, obs[2].fb}); else passed++;
    checks++; if ({obs[3].in2d, obs[3].in2s, obs[3].fb} !== 3'b101) $display("FAIL dbl_d3_in2 got %b want 101", {obs[3].in2d, obs[3].in2s, obs[3].fb}); else passed++;
    checks++; if (obs[3].sel !== 4'b1000) $display("FAIL dbl_d3_sel got %b want 1000", obs[3].sel); else passed++;
    checks++; if ({obs[4].sub, obs[4].add, obs[5].sub, obs[5].add} !== 4'b1001) $display("FAIL dbl_shl got %b want 1001", {obs[4].sub, obs[4].add, obs[5].sub, obs[5].add}); else passed++;
    checks++; if (obs[60].e5a !== 1'b0) $display("FAIL dbl_iter_len e5a@60 got %b want 0", obs[60].e5a); else passed++;
    checks++; if ({obs[61].e5a, obs[61].e5d, obs[61].e5s, obs[61].ldo, obs[61].cin} !== 5'b11010)
      $display("FAIL dbl_b5 got %b want 11010", {obs[61].e5a, obs[61].e5d, obs[61].e5s, obs[61].ldo, obs[61].cin}); else passed++;
    checks++; if ({obs[62].e6, obs[62].cin, obs[62].ldo} !== 3'b101) $display("FAIL dbl_b6 got %b want 101", {obs[62].e6, obs[62].cin, obs[62].ldo}); else passed++;
    checks++; if ({obs[63].e7, obs[63].cin, obs[63].ldo} !== 3'b101) $display("FAIL dbl_b7 got %b want 101", {obs[63].e7, obs[63].cin, obs[63].ldo}); else passed++;
  endtask

  task automatic test_single();
    int lat, nd;
    bus.no_decr = 1'b0;
    bus.rnd_cin = 1'b1;
    run_req(1'b0, 2'b00, 0, 0, lat, nd);
    checks++; if (lat !== 35) $display("FAIL sng_latency got %0d want 35", lat); else passed++;
    checks++; if (nd !== 1) $display("FAIL sng_done_count got %0d want 1", nd); else passed++;
    checks++; if ({obs[2].in1d, obs[2].in1s} !== 2'b01) $display("FAIL sng_d2_in1 got %b want 01", {obs[2].in1d, obs[2].in1s}); else passed++;
    checks++; if ({obs[3].in2d, obs[3].in2s} !== 2'b01) $display("FAIL sng_d3_in2 got %b want 01", {obs[3].in2d, obs[3].in2s}); else passed++;
    checks++; if (obs[31].e5a !== 1'b0) $display("FAIL sng_iter_len e5a@31 got %b want 0", obs[31].e5a); else passed++;
    checks++; if ({obs[32].e5a, obs[32].e5d, obs[32].e5s, obs[32].ldo, obs[32].cin} !== 5'b10110)
      $display("FAIL sng_b5 got %b want 10110", {obs[32].e5a, obs[32].e5d, obs[32].e5s, obs[32].ldo, obs[32].cin}); else passed++;
    checks++; if ({obs[33].e6, obs[33].cin, obs[33].ldo} !== 3'b111) $display("FAIL sng_b6_nodecr got %b want 111", {obs[33].e6, obs[33].cin, obs[33].ldo}); else passed++;
    checks++; if ({obs[34].e7, obs[34].cin, obs[34].ldo} !== 3'b111) $display("FAIL sng_b7_rnd got %b want 111", {obs[34].e7, obs[34].cin, obs[34].ldo}); else passed++;
  endtask

  task automatic test_special();
    int lat, nd;
    bus.no_decr = 1'b1;
    bus.rnd_cin = 1'b0;
    run_req(1'b1, 2'b10, 0, 0, lat, nd);
    checks++; if ({obs[2].sel, obs[3].sel, obs[4].sel} !== 12'b1000_0100_1000)
      $display("FAIL sr10_sel got %b want 100001001000", {obs[2].sel, obs[3].sel, obs[4].sel}); else passed++;
    checks++; if (obs[3].ld1 !== 1'b1) $display("FAIL sr10_load got %b want 1", obs[3].ld1); else passed++;
    checks++; if (lat !== LAT_SR_D) $display("FAIL sr10_latency got %0d want %0d", lat, LAT_SR_D); else passed++;
    run_req(1'b0, 2'b01, 0, 0, lat, nd);
    checks++; if (obs[3].sel !== 4'b0001) $display("FAIL sr01_sel got %b want 0001", obs[3].sel); else passed++;
    checks++; if (lat !== LAT_SR_S) $display("FAIL sr01_latency got %0d want %0d", lat, LAT_SR_S); else passed++;
    run_req(1'b0, 2'b11, 0, 0, lat, nd);
    checks++; if (obs[3].sel !== 4'b0010) $display("FAIL sr11_sel got %b want 0010", obs[3].sel); else passed++;
    bus.special_res = 2'b00;
  endtask

  task automatic test_hold();
    int lat, nd;
    bus.no_decr = 1'b1;
    bus.rnd_cin = 1'b0;
    run_req(1'b1, 2'b00, 20, 5, lat, nd);
    checks++; if (lat !== 69) $display("FAIL hold_iter_latency got %0d want 69", lat); else passed++;
    checks++; if (nd !== 1) $display("FAIL hold_iter_done_count got %0d want 1", nd); else passed++;
    for (int n = 20; n < 25; n++) begin
      checks++;
      if ({obs[n].ld1, obs[n].ldo, obs[n].d1} !== 3'b000) $display("FAIL hold_iter_loads cyc %0d got %b want 000", n, {obs[n].ld1, obs[n].ldo, obs[n].d1});
      else passed++;
    end
    run_req(1'b1, 2'b00, 61, 2, lat, nd);
    checks++; if ({obs[61].e5a, obs[61].ldo, obs[62].e5a, obs[62].ldo, obs[63].e5a, obs[63].ldo} !== 6'b101011)
      $display("FAIL hold_b5 got %b want 101011", {obs[61].e5a, obs[61].ldo, obs[62].e5a, obs[62].ldo, obs[63].e5a, obs[63].ldo}); else passed++;
    checks++; if (lat !== 66) $display("FAIL hold_b5_latency got %0d want 66", lat); else passed++;
    run_req(1'b0, 2'b00, 2, 1, lat, nd);
    checks++; if ({obs[2].in1s, obs[2].ld1, obs[3].in1s, obs[3].ld1} !== 4'b1011)
      $display("FAIL hold_d2 got %b want 1011", {obs[2].in1s, obs[2].ld1, obs[3].in1s, obs[3].ld1}); else passed++;
    checks++; if (lat !== 36) $display("FAIL hold_d2_latency got %0d want 36", lat); else passed++;
  endtask

  task automatic test_hold_idle();
    bus.hold    = 1'b1;
    bus.req_vld = 1'b1;
    bus.req_dbl = 1'b1;
    #1;
    checks++; if ({bus.req_rdy, bus.d1stg_step} !== 2'b00) $display("FAIL hold_idle got %b want 00", {bus.req_rdy, bus.d1stg_step}); else passed++;
    tick();
    tick();
    bus.hold    = 1'b0;
    bus.req_vld = 1'b0;
    #1;
    checks++; if ({bus.req_rdy, bus.exp1_load} !== 2'b10) $display("FAIL hold_idle_release got %b want 10", {bus.req_rdy, bus.exp1_load}); else passed++;
  endtask

  task automatic test_reset_midop();
    int lat, nd;
    bus.no_decr     = 1'b1;
    bus.special_res = 2'b00;
    bus.req_vld     = 1'b1;
    bus.req_dbl     = 1'b0;
    for (int n = 0; n < 33; n++) begin
      tick();
      bus.req_vld = 1'b0;
    end
    #1;
    checks++; if (bus.e6_fdiv !== 1'b1) $display("FAIL midrst_in_b6 got %b want 1", bus.e6_fdiv); else passed++;
    reset    = 1'b1;
    bus.hold = 1'b1;
    tick();
    reset    = 1'b0;
    bus.hold = 1'b0;
    #1;
    checks++; if ({bus.req_rdy, bus.e6_fdiv, bus.e7_fdiv, bus.div_done} !== 4'b1000)
      $display("FAIL midrst_idle got %b want 1000", {bus.req_rdy, bus.e6_fdiv, bus.e7_fdiv, bus.div_done}); else passed++;
    run_req(1'b0, 2'b00, 0, 0, lat, nd);
    checks++; if (obs[0].d1 !== 1'b1) $display("FAIL midrst_new_accept got %b want 1", obs[0].d1); else passed++;
    checks++; if (lat !== 35) $display("FAIL midrst_new_latency got %0d want 35", lat); else passed++;
    checks++; if (nd !== 1) $display("FAIL midrst_done_count got %0d want 1", nd); else passed++;
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int dn[$];
    bus.req_vld     = 1'b1;
    bus.req_dbl     = 1'b1;
    bus.special_res = 2'b00;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (bus.d1stg_step === 1'b1) acc.push_back(n);
      if (bus.div_done === 1'b1) dn.push_back(n);
      tick();
    end
    bus.req_vld = 1'b0;
    checks++; if (acc.size() !== 4) $display("FAIL b2b_accepts got %0d want 4", acc.size()); else passed++;
    checks++; if (dn.size() !== 3) $display("FAIL b2b_dones got %0d want 3", dn.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= acc.size()) $display("FAIL b2b_accept_at idx %0d got none want %0d", i, 65 * i);
      else if (acc[i] !== 65 * i) $display("FAIL b2b_accept_at idx %0d got %0d want %0d", i, acc[i], 65 * i);
      else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= dn.size()) $display("FAIL b2b_done_at idx %0d got none want %0d", i, 65 * i + 64);
      else if (dn[i] !== 65 * i + 64) $display("FAIL b2b_done_at idx %0d got %0d want %0d", i, dn[i], 65 * i + 64);
      else passed++;
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.req_vld     = 1'b0;
    bus.req_dbl     = 1'b0;
    bus.special_res = 2'b00;
    bus.no_decr     = 1'b1;
    bus.rnd_cin     = 1'b0;
    bus.hold        = 1'b0;
    test_reset();
    test_double();
    test_single();
    test_special();
    test_hold();
    test_hold_idle();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fpu_div_exp_ctl.md
Name: fpu_div_exp_ctl

Overview:
- Sequencing controller for the divide exponent datapath.
- Accepts one divide request at a time, walks it through the stage sequence front-end, mantissa iteration, back-end.
- Generates every one-hot select, load enable and carry for the exponent adders and registers, then signals completion.
- Sits beside the exponent datapath inside the divide pipe; the front end is driven by the issue queue, the back end by the fraction/round logic.

Parameters:
- ITER_DBL, 55, mantissa iteration cycles for double.
- ITER_SNG, 26, mantissa iteration cycles for single.
- CNT_W, 6, iteration counter width; must hold ITER_DBL.

Ports:
- rclk  in  1  global clock.
- reset  in  1  synchronous, active-high reset.
- req_vld  in  1  divide request present.
- req_dbl  in  1  1 = double, 0 = single; sampled with req_vld.
- req_rdy  out  1  controller idle, request accepted this cycle.
- special_res  in  2  from D3 onward: 00 normal, 01 force zero, 10 force 0x0835, 11 force 0x0118.
- no_decr  in  1  fraction normalized; drives no-decrement in D6.
- rnd_cin  in  1  rounding carry for D7.
- hold  in  1  freeze all state, counters and enables.
- d1stg_step  out  1  capture operand exponents.
- sel_exp1_fb  out  1  adder-1 in1 = exp1 (D3, D4, D5).
- sel_in1_dbl, sel_in1_sng  out  1 each  adder-1 in1 = operand 1 + bias (D2).
- sel_in2_dbl, sel_in2_sng  out  1 each  adder-1 in2 = ~operand 2 (D3).
- sel_sub_shl, sel_add_shl  out  1 each  adder-1 in2 = ~shift / +shift (D4 / D5).
- exp1_sel  out  4  one-hot {expadd1, 0835, 0118, zero}.
- exp1_load  out  1  exp1 register enable.
- e5_fdiva, e5_fdivd, e5_fdivs, e6_fdiv, e7_fdiv  out  1 each  back-end stage selects.
- expadd2_cin  out  1  adder-2 carry.
- exp_out_load  out  1  exp_out register enable.
- div_done  out  1  one-cycle result-valid pulse.

Behaviour:
- States: IDLE, D1, D2, D3, D4, D5, ITER, B5, B6, B7, DONE. Encoding is one-hot.
- Reset: state = IDLE, counter = 0, dbl flag = 0. All outputs 0 except req_rdy = 1.
- IDLE: req_rdy = 1. If req_vld, then latch req_dbl, assert d1stg_step and go to D1. d1stg_step is combinational on req_vld & IDLE.
- D1 -> D2 -> D3 -> D4 -> D5: one cycle each. exp1_load = 1 and exp1_sel = expadd1 in D2 through D5.
- In D3 only: exp1_sel follows special_res (zero / 0835 / 0118) when special_res != 00.
- ITER: counter loads ITER_DBL-1 or ITER_SNG-1 on entry and decrements each cycle. Exit to B5 when counter == 0. Total ITER cycles = ITER_DBL or ITER_SNG exactly.
- B5: e5_fdiva = 1; e5_fdivd / e5_fdivs per dbl flag; expadd2_cin = 0; exp_out_load = 1.
- B6: e6_fdiv = 1; expadd2 no-decrement input = ~no_decr; exp_out_load = 1.
- B7: e7_fdiv = 1; expadd2_cin = rnd_cin; exp_out_load = 1.
- DONE: div_done = 1 for exactly one cycle, then IDLE.
- Back-to-back: IDLE is re-entered the cycle after DONE, so a new request is accepted 1 cycle after div_done.
- Latency: req accept to div_done = 9 + ITER cycles (64 double, 35 single).
- hold = 1: state and counter frozen; all load enables and d1stg_step forced 0; selects keep their values. hold in IDLE also forces req_rdy = 0.
- Simultaneous reset and hold: reset wins.
- Reset mid-operation: next cycle is IDLE, the request is discarded, and no div_done is issued.
- All select outputs are mutually exclusive within each adder-input group. Assertion-checked.

Optional Feature:
- FPU_DIV_EARLY_OUT_EN defined: if special_res != 00 in D3, the dbl flag path skips ITER. D5 goes directly to B5. Latency is 9 cycles.
- Undefined: ITER always runs its full count; special_res affects only exp1_sel.

Decomposition:
- Shared package fpu_div_pkg: state encoding, special_res codes, exp1 constants 13'h0835 / 13'h0118, default iteration counts.
- One sub-module: fpu_div_iter_cnt. It is the loadable down-counter with hold and a zero flag.

Test Plan:
- Double request, no_decr = 1, rnd_cin = 0 -> div_done exactly 64 cycles after accept. exp1_load high D2–D5. e5_fdivd = 1, e5_fdivs = 0.
- Single request -> div_done at 35 cycles. sel_in1_sng in D2, sel_in2_sng in D3. ITER lasts 26 cycles.
- special_res = 10 in D3 -> exp1_sel = 0100 that cycle. With FPU_DIV_EARLY_OUT_EN, div_done at 9 cycles.
- hold asserted 5 cycles mid-ITER -> div_done delayed by exactly 5; no load enables during hold.
- reset asserted in B6 -> state IDLE, req_rdy = 1 next cycle, no div_done. A new req_vld is accepted immediately.
- req_vld held high continuously -> accepts exactly one request per 65 cycles (double), each with a single div_done pulse.
